regfile_port_arbiter: RTL

Arbitrates access to the 16x32 register file. The register file has one write port and two read ports, and a write cycle suppresses the read ports. Two writeback sources (ALU and load unit) share the write port round-robin. One operand-fetch requester issues paired reads. The arbiter enforces a read-after-write interlock, bounds read starvation, and returns read data one cycle after grant. It sits between the execute/writeback stages and the register file.

---
 rtl/regfile_port_arbiter_if.sv | 66 ++++++
 rtl/regfile_port_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/regfile_port_arbiter_if.sv
// ============================================================================
// Module      : regfile_port_arbiter_if
// Description : Writeback, operand-read and register-file signals of the
//               register-file port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_port_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                  wb0_valid;
  logic                  wb0_ready;
  logic [ADDR_WIDTH-1:0] wb0_addr;
  logic [DATA_WIDTH-1:0] wb0_data;

  logic                  wb1_valid;
  logic                  wb1_ready;
  logic [ADDR_WIDTH-1:0] wb1_addr;
  logic [DATA_WIDTH-1:0] wb1_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic                  rd_resp_valid;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;

  logic                  rf_write;
  logic [ADDR_WIDTH-1:0] rf_write_addr;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic [ADDR_WIDTH-1:0] rf_read_addr_a;
  logic [ADDR_WIDTH-1:0] rf_read_addr_b;
  logic [DATA_WIDTH-1:0] rf_read_data_a;
  logic [DATA_WIDTH-1:0] rf_read_data_b;

  // Arbiter side
  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rd_valid, rd_addr_a, rd_addr_b,
    input  rf_read_data_a, rf_read_data_b,
    output wb0_ready, wb1_ready, rd_ready,
    output rd_resp_valid, rd_data_a, rd_data_b,
    output rf_write, rf_write_addr, rf_write_data,
    output rf_read_addr_a, rf_read_addr_b
  );

  // Requester / register-file side
  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rd_valid, rd_addr_a, rd_addr_b,
    output rf_read_data_a, rf_read_data_b,
    input  wb0_ready, wb1_ready, rd_ready,
    input  rd_resp_valid, rd_data_a, rd_data_b,
    input  rf_write, rf_write_addr, rf_write_data,
    input  rf_read_addr_a, rf_read_addr_b
  );

endinterface

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// Module      : regfile_port_arbiter
// Description : Single-grant arbiter for a 1W/2R register file: round-robin
//               between two writeback sources, RAW-interlocked paired reads
//               with bounded starvation and a one-cycle read response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_arbiter #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  wire                     clk,
  input  wire                     reset,
  regfile_port_arbiter_if.slave   bus
);

  localparam int              c_WCW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_WCW-1:0] c_LIMIT   = c_WCW'(STARVE_LIMIT);
  localparam logic            c_RR_WB0   = 1'b0;
  localparam logic            c_RR_WB1   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = '0;

  logic [c_WCW-1:0] r_wait_cnt;
  logic             r_rr_last;
  logic             r_resp_valid;

  logic w_haz0;
  logic w_haz1;
  logic w_hazard;
  logic w_rd_prio;
  logic w_any_wr;
  logic w_gnt_wb0;
  logic w_gnt_wb1;
  logic w_gnt_rd;

  // Address 0 is hard-wired in the register file, so it never creates a RAW.
  assign w_haz0 = bus.wb0_valid && (bus.wb0_addr != c_ZERO_ADDR) &&
                  ((bus.wb0_addr == bus.rd_addr_a) || (bus.wb0_addr == bus.rd_addr_b));
  assign w_haz1 = bus.wb1_valid && (bus.wb1_addr != c_ZERO_ADDR) &&
                  ((bus.wb1_addr == bus.rd_addr_a) || (bus.wb1_addr == bus.rd_addr_b));
  assign w_hazard = w_haz0 || w_haz1;

  assign w_rd_prio = bus.rd_valid && !w_hazard && (r_wait_cnt == c_LIMIT);
  assign w_any_wr  = bus.wb0_valid || bus.wb1_valid;

  assign w_gnt_rd  = reset && bus.rd_valid && !w_hazard && (w_rd_prio || !w_any_wr);
  assign w_gnt_wb0 = reset && !w_rd_prio && bus.wb0_valid &&
                     (!bus.wb1_valid || (r_rr_last == c_RR_WB1));
  assign w_gnt_wb1 = reset && !w_rd_prio && bus.wb1_valid &&
                     (!bus.wb0_valid || (r_rr_last == c_RR_WB0));

  assign bus.wb0_ready = w_gnt_wb0;
  assign bus.wb1_ready = w_gnt_wb1;
  assign bus.rd_ready  = w_gnt_rd;

  assign bus.rf_write      = w_gnt_wb0 || w_gnt_wb1;
  assign bus.rf_write_addr = w_gnt_wb1 ? bus.wb1_addr : bus.wb0_addr;
  assign bus.rf_write_data = w_gnt_wb1 ? bus.wb1_data : bus.wb0_data;

  assign bus.rf_read_addr_a = bus.rd_addr_a;
  assign bus.rf_read_addr_b = bus.rd_addr_b;

  // Gated by reset so a grant just before reset never surfaces a response.
  assign bus.rd_resp_valid = r_resp_valid && reset;
  assign bus.rd_data_a     = bus.rf_read_data_a;
  assign bus.rd_data_b     = bus.rf_read_data_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_wait_cnt   <= '0;
      r_rr_last    <= c_RR_WB1;
    end else begin
      r_resp_valid <= w_gnt_rd;

      if (!bus.rd_valid || w_gnt_rd) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != c_LIMIT) begin
        r_wait_cnt <= r_wait_cnt + c_WCW'(1);
      end

      if (w_gnt_wb0) begin
        r_rr_last <= c_RR_WB0;
      end else if (w_gnt_wb1) begin
        r_rr_last <= c_RR_WB1;
      end
    end
  end

endmodule

`default_nettype wire
